// File: rtl/ps2_pkg.sv
// rtl/ps2_pkg.sv - shared constants, types and byte classifier for the PS/2 scan-code decoder
package ps2_pkg;

  localparam logic [7:0] PS2_E0     = 8'hE0;
  localparam logic [7:0] PS2_F0     = 8'hF0;
  localparam logic [7:0] PS2_E1     = 8'hE1;
  localparam logic [7:0] PS2_BAT_OK = 8'hAA;
  localparam logic [7:0] PS2_ACK    = 8'hFA;
  localparam logic [7:0] PS2_ECHO   = 8'hEE;
  localparam logic [7:0] PS2_RESEND = 8'hFE;

  localparam logic [7:0] KEY_LSHIFT = 8'h12;
  localparam logic [7:0] KEY_RSHIFT = 8'h59;
  localparam logic [7:0] KEY_CTRL   = 8'h14;
  localparam logic [7:0] KEY_ALT    = 8'h11;
  localparam logic [7:0] KEY_CAPS   = 8'h58;
  localparam logic [7:0] KEY_PAUSE  = 8'h77;

  localparam logic [2:0] E1_SKIP_LEN = 3'd7;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PRE_E0,
    ST_PRE_F0,
    ST_PRE_E0F0,
    ST_SKIP_E1
  } ps2_state_t;

  typedef struct packed {
    logic       is_release;
    logic       ext;
    logic [7:0] code;
  } ps2_event_t;

  typedef struct packed {
    ps2_state_t state;
    logic       push;
    logic       err;
  } ps2_step_t;

  // What a byte does when it arrives with no prefix pending.
  function automatic ps2_step_t idle_step(input logic [7:0] b);
    ps2_step_t s;
    s.state = ST_IDLE;
    s.push  = 1'b0;
    s.err   = 1'b0;
    case (b)
      PS2_E0:                                    s.state = ST_PRE_E0;
      PS2_F0:                                    s.state = ST_PRE_F0;
      PS2_E1:                                    s.state = ST_SKIP_E1;
      PS2_BAT_OK, PS2_ACK, PS2_ECHO, PS2_RESEND: s.push  = 1'b0;
      8'h00, 8'hFF:                              s.err   = 1'b1;
      default:                                   s.push  = 1'b1;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/ps2_event_fifo.sv
// rtl/ps2_event_fifo.sv - synchronous show-ahead FIFO for decoded key events
module ps2_event_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 4
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_push_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_head,
  output logic             o_valid,
  output logic             o_overflow
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             r_overflow;
  logic             w_full;
  logic             w_do_pop;
  logic             w_do_push;

  assign o_valid   = (r_count != '0);
  assign w_full    = (r_count == (AW+1)'(DEPTH));
  assign w_do_pop  = i_pop && o_valid;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign w_do_push = i_push && (!w_full || w_do_pop);

  assign o_head     = o_valid ? r_mem[r_rd_ptr] : '0;
  assign o_overflow = r_overflow;

  always_ff @(posedge i_clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_push_data;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_overflow <= i_push && !w_do_push;
      if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/ps2_scancode_decoder.sv
// rtl/ps2_scancode_decoder.sv - Set-2 scan-code sequence decoder with event FIFO and modifier tracking
module ps2_scancode_decoder
  import ps2_pkg::*;
#(
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic       CLOCK,
  input  logic       RESET,
  input  logic [7:0] RX_data,
  input  logic       VALID_data,
  output logic [7:0] ev_code,
  output logic       ev_ext,
  output logic       ev_release,
  output logic       ev_valid,
  input  logic       ev_ready,
  output logic       mod_shift,
  output logic       mod_ctrl,
  output logic       mod_alt,
  output logic       caps_lock,
  output logic       overflow,
  output logic       seq_error
);

  localparam int            TW      = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);

  logic          r_valid_d;
  ps2_state_t    r_state;
  logic [2:0]    r_skip;
  logic [TW-1:0] r_to_cnt;
  logic          r_push;
  ps2_event_t    r_ev;
  logic          r_seq_err;
  logic          r_lshift, r_rshift, r_lctrl, r_rctrl, r_lalt, r_ralt;
  logic          r_caps, r_caps_held;

  logic          w_accept;
  logic          w_prefix;
  ps2_step_t     w_idle;
  ps2_event_t    w_head;

  assign w_accept = VALID_data && !r_valid_d;
  assign w_idle   = idle_step(RX_data);
  assign w_prefix = (RX_data == PS2_E0) || (RX_data == PS2_F0) || (RX_data == PS2_E1);

  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      r_valid_d <= 1'b0;
      r_state   <= ST_IDLE;
      r_skip    <= '0;
      r_to_cnt  <= '0;
      r_push    <= 1'b0;
      r_ev      <= '0;
      r_seq_err <= 1'b0;
    end else begin
      r_valid_d <= VALID_data;
      r_push    <= 1'b0;
      r_seq_err <= 1'b0;
      if (w_accept) begin
        r_to_cnt <= '0;
        r_ev     <= {1'b0, 1'b0, RX_data};
        if (r_state != ST_SKIP_E1) r_skip <= E1_SKIP_LEN;
        case (r_state)
          ST_IDLE: begin
            r_state   <= w_idle.state;
            r_push    <= w_idle.push;
            r_seq_err <= w_idle.err;
          end
          ST_PRE_E0: begin
            if (RX_data == PS2_F0) begin
              r_state <= ST_PRE_E0F0;
            end else if (w_prefix) begin
              r_state   <= w_idle.state;
              r_seq_err <= 1'b1;
            end else begin
              // E0 12 is the fake shift wrapped around extended keys
              r_state   <= ST_IDLE;
              r_push    <= (RX_data != KEY_LSHIFT);
              r_ev.ext  <= 1'b1;
            end
          end
          ST_PRE_F0: begin
            if (w_prefix) begin
              r_state   <= w_idle.state;
              r_seq_err <= 1'b1;
            end else begin
              r_state         <= ST_IDLE;
              r_push          <= 1'b1;
              r_ev.is_release <= 1'b1;
            end
          end
          ST_PRE_E0F0: begin
            if (w_prefix) begin
              r_state   <= w_idle.state;
              r_seq_err <= 1'b1;
            end else begin
              r_state         <= ST_IDLE;
              r_push          <= (RX_data != KEY_LSHIFT);
              r_ev.is_release <= 1'b1;
              r_ev.ext        <= 1'b1;
            end
          end
          ST_SKIP_E1: begin
            if (r_skip == 3'd1) begin
              r_state <= ST_IDLE;
              r_push  <= 1'b1;
              r_ev    <= {1'b0, 1'b1, KEY_PAUSE};
            end else begin
              r_skip <= r_skip - 3'd1;
            end
          end
          default: r_state <= ST_IDLE;
        endcase
      end else if (r_state != ST_IDLE) begin
        if (r_to_cnt == TO_LAST) begin
          r_state   <= ST_IDLE;
          r_to_cnt  <= '0;
          r_seq_err <= 1'b1;
        end else begin
          r_to_cnt <= r_to_cnt + TW'(1);
        end
      end
    end
  end

  // Modifier flags follow every decoded event, even one the FIFO drops.
  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      r_lshift    <= 1'b0;
      r_rshift    <= 1'b0;
      r_lctrl     <= 1'b0;
      r_rctrl     <= 1'b0;
      r_lalt      <= 1'b0;
      r_ralt      <= 1'b0;
      r_caps      <= 1'b0;
      r_caps_held <= 1'b0;
    end else if (r_push) begin
      if (!r_ev.ext) begin
        case (r_ev.code)
          KEY_LSHIFT: r_lshift <= !r_ev.is_release;
          KEY_RSHIFT: r_rshift <= !r_ev.is_release;
          KEY_CTRL:   r_lctrl  <= !r_ev.is_release;
          KEY_ALT:    r_lalt   <= !r_ev.is_release;
          KEY_CAPS: begin
            if (r_ev.is_release) begin
              r_caps_held <= 1'b0;
            end else if (!r_caps_held) begin
              r_caps_held <= 1'b1;
              r_caps      <= !r_caps;
            end
          end
          default: r_caps_held <= r_caps_held;
        endcase
      end else begin
        case (r_ev.code)
          KEY_CTRL: r_rctrl <= !r_ev.is_release;
          KEY_ALT:  r_ralt  <= !r_ev.is_release;
          default:  r_rctrl <= r_rctrl;
        endcase
      end
    end
  end

  ps2_event_fifo #(
    .WIDTH ($bits(ps2_event_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk       (CLOCK),
    .i_rst_n     (RESET),
    .i_push      (r_push),
    .i_push_data (r_ev),
    .i_pop       (ev_ready),
    .o_head      (w_head),
    .o_valid     (ev_valid),
    .o_overflow  (overflow)
  );

  assign ev_code    = w_head.code;
  assign ev_ext     = w_head.ext;
  assign ev_release = w_head.is_release;
  assign mod_shift  = r_lshift || r_rshift;
  assign mod_ctrl   = r_lctrl || r_rctrl;
  assign mod_alt    = r_lalt || r_ralt;
  assign caps_lock  = r_caps;
  assign seq_error  = r_seq_err;

endmodule

// File: doc/ps2_scancode_decoder.md
Name: ps2_scancode_decoder

Overview:
- Downstream stage of the PS/2 byte receiver. Consumes its RX_data/VALID_data byte stream and decodes Set-2 scan-code sequences (E0 extended prefix, F0 break prefix, E1 Pause sequence) into single key events.
- Events are buffered in a small show-ahead FIFO with a valid/ready pop handshake.
- Also tracks the modifier keys and the Caps Lock state for the keyboard front end.

Parameters:
- FIFO_DEPTH, 4: event FIFO entries; power of two, minimum 2.
- TIMEOUT_CYCLES, 1000000: CLOCK cycles allowed in any prefix state before it is abandoned (20 ms at 50 MHz).

Ports:
- CLOCK  in  1  system clock; every register in the block is on its rising edge.
- RESET  in  1  asynchronous, active-low reset.
- RX_data  in  8  byte from the PS/2 receiver; stable while VALID_data is high.
- VALID_data  in  1  byte-valid from the receiver, synchronous to CLOCK.
- ev_code  out  8  scan code of the FIFO head event.
- ev_ext  out  1  head event carried an E0 prefix (or is Pause).
- ev_release  out  1  head event is a break (F0 seen).
- ev_valid  out  1  FIFO not empty.
- ev_ready  in  1  consumer accepts the head event.
- mod_shift  out  1  left (12) or right (59) Shift held.
- mod_ctrl  out  1  left (14) or right (E0 14) Ctrl held.
- mod_alt  out  1  left (11) or right (E0 11) Alt held.
- caps_lock  out  1  Caps Lock toggle state.
- overflow  out  1  one-cycle pulse: an event was dropped because the FIFO was full.
- seq_error  out  1  one-cycle pulse: a sequence was abandoned (timeout or illegal byte).

Behaviour:
- Reset (RESET low, asynchronous): all outputs 0, FIFO empty, FSM in IDLE, timeout counter 0, held-key flags cleared.
- Byte acceptance: one byte is accepted per rising edge of VALID_data (registered edge detect). VALID_data held high for several cycles yields exactly one byte.
- FSM states are IDLE, PRE_E0, PRE_F0, PRE_E0F0 and SKIP_E1, with these transitions on each accepted byte:
  - IDLE: E0 goes to PRE_E0; F0 goes to PRE_F0; E1 goes to SKIP_E1 with the skip counter set to 7.
  - IDLE: AA, FA, EE and FE are dropped silently. 00 and FF are dropped and pulse seq_error.
  - IDLE: any other byte pushes {release=0, ext=0, code}.
  - PRE_E0: F0 goes to PRE_E0F0. Byte 12 (fake shift) is dropped and returns to IDLE. Any other byte pushes {0,1,code} and returns to IDLE.
  - PRE_F0: pushes {1,0,code} and returns to IDLE.
  - PRE_E0F0: byte 12 is dropped; any other byte pushes {1,1,code}. Either way, return to IDLE.
  - Prefix states: a prefix byte (E0, F0, E1) received in PRE_F0 or PRE_E0F0, or E0/E1 in PRE_E0, pulses seq_error, and the FSM restarts as if that byte had arrived in IDLE.
  - SKIP_E1: each byte decrements the counter. At 0, push {0,1,8'h77} (Pause make) and return to IDLE.
- Timeout: in any non-IDLE state, the counter increments every cycle and clears on each accepted byte. Reaching TIMEOUT_CYCLES-1 returns the FSM to IDLE, pulses seq_error and pushes nothing.
- Latency: VALID_data rises in cycle N; the push happens at the end of cycle N+1; ev_valid is high in cycle N+2 if the FIFO was empty. Modifier and caps outputs update in the same cycle as the push.
- FIFO:
  - Show-ahead: ev_* always present the head entry.
  - Pop when ev_valid && ev_ready.
  - Push to a full FIFO with a simultaneous pop succeeds.
  - Push to a full FIFO without a pop drops the new event and pulses overflow. Modifiers still update.
  - Pointers wrap modulo FIFO_DEPTH.
  - Occupancy is tracked with a count register of width clog2(FIFO_DEPTH)+1.
- Modifiers: each of the six modifier keys has a held flag, set on make and cleared on break, independent of FIFO state. mod_* is the OR of the left and right flags.
- Caps Lock:
  - A non-extended make of 58 while caps_held=0 toggles caps_lock and sets caps_held.
  - Typematic repeats of 58 (caps_held=1) do not toggle.
  - A break of 58 clears caps_held.
- Reset mid-sequence: all state is lost; a trailing partial sequence after reset is decoded from IDLE.

Decomposition:
- Package ps2_pkg holds:
  - byte constants PS2_E0, PS2_F0, PS2_E1, PS2_BAT_OK, PS2_ACK, PS2_ECHO and PS2_RESEND;
  - modifier code constants;
  - the FSM state enum;
  - an event struct {release, ext, code[7:0]}.
- One sub-module, ps2_event_fifo (synchronous show-ahead FIFO, parameterised width and depth); decode and modifier logic stay in the top module.

Test Plan:
- Bytes 1C; F0 1C with ev_ready=1 -> events {0,0,1C} then {1,0,1C}; ev_valid is high exactly 2 cycles after each completing VALID_data.
- Bytes E0 75, then E0 F0 75 -> {0,1,75} then {1,1,75}. Bytes E0 12 E0 7C (PrtScr make) -> only {0,1,7C}; mod_shift stays 0.
- Bytes E1 14 77 E1 F0 14 F0 77 -> a single {0,1,77} event. 12 then 59, then F0 12 -> mod_shift stays 1 until F0 59.
- Bytes 58 58 58, F0 58, 58 -> caps_lock goes 0→1 (stays 1 through repeats), then 1→0 on the second press.
- ev_ready=0, bytes 15 1D 24 2D 2C -> ev_valid=1 with head 15, overflow pulses once (on 2C), four events drain in order. With the FIFO full, a push coinciding with a pop is not dropped.
- Byte E0, then silence for TIMEOUT_CYCLES (reduced to 50) -> seq_error pulses and the FSM returns to IDLE. A following 1C yields {0,0,1C}. RESET low between F0 and 1C -> outputs 0, and the next 1C yields a make.
